// File: rtl/sl_pkg.sv
// Shared SL receiver definitions: config register layout, line symbol codes
// and the one-hot FSM state encoding.
package sl_pkg;
    localparam int BQL  = 0;
    localparam int BQH  = 5;
    localparam int IRQM = 6;
    localparam logic [7:0] CFG_RST = 8'h20;

    // Symbol code is {SL0, SL1}
    typedef enum logic [1:0] {
        SYM_STOP = 2'b00,
        SYM_ZERO = 2'b01,
        SYM_ONE  = 2'b10,
        SYM_IDLE = 2'b11
    } sym_t;

    localparam int ST_IDLE   = 0;
    localparam int ST_BIT    = 1;
    localparam int ST_GAP    = 2;
    localparam int ST_PARITY = 3;
    localparam int ST_PGAP   = 4;
    localparam int ST_STOP   = 5;
    localparam int ST_ERR    = 6;

    typedef enum logic [6:0] {
        IDLE   = 7'd1 << ST_IDLE,
        BIT    = 7'd1 << ST_BIT,
        GAP    = 7'd1 << ST_GAP,
        PARITY = 7'd1 << ST_PARITY,
        PGAP   = 7'd1 << ST_PGAP,
        STOP   = 7'd1 << ST_STOP,
        ERR    = 7'd1 << ST_ERR
    } state_t;
endpackage

// File: rtl/sl_line_sync.sv
// Synchroniser for both SL lines, producing the decoded symbol and a change strobe.
// With SL_GLITCH_FILTER_EN defined, each line also passes a FILT_LEN-deep stable filter.
module sl_line_sync
    import sl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef SL_GLITCH_FILTER_EN
    ,
    parameter int FILT_LEN    = 3
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] line,
    output sym_t       sym,
    output logic       chg
);
    logic [1:0] cur;
    logic [1:0] prev;

    for (genvar i = 0; i < 2; i++) begin : g_line
        logic [SYNC_STAGES-1:0] ff;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) ff <= '1;
            else        ff <= {ff[SYNC_STAGES-2:0], line[i]};
        end
`ifdef SL_GLITCH_FILTER_EN
        logic [FILT_LEN-1:0] hist;
        logic                filt;
        // Output moves only once the whole history agrees
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hist <= '1;
                filt <= 1'b1;
            end else begin
                hist <= {hist[FILT_LEN-2:0], ff[SYNC_STAGES-1]};
                if (&hist)       filt <= 1'b1;
                else if (~|hist) filt <= 1'b0;
            end
        end
        assign cur[i] = filt;
`else
        assign cur[i] = ff[SYNC_STAGES-1];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 2'b11;
        else        prev <= cur;
    end

    assign chg = (cur != prev);
    assign sym = sym_t'(cur);
endmodule

// File: rtl/sl_receiver.sv
// SL link receiver: decodes {SL0,SL1} symbols into a word with parity and framing checks.
// Optional glitch filter on the synced lines is enabled by defining SL_GLITCH_FILTER_EN.
module sl_receiver
    import sl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
`ifdef SL_GLITCH_FILTER_EN
    ,
    parameter int FILT_LEN    = 3
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SL0,
    input  logic        SL1,
    input  logic [7:0]  wr_config_w,
    input  logic        cfg_wr,
    output logic [7:0]  r_config_w,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ack,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun,
    output logic        rx_busy
);
    localparam int TW         = $clog2(TIMEOUT_CYC + 1);
    localparam int RESYNC_CYC = 16;

    state_t        state, state_nx;
    sym_t          sym;
    logic          chg, tmo, err, start, bump, take_bit, take_par, done, bit_val;
    logic [TW-1:0] tcnt;
    logic [5:0]    bitcnt, nbits;
    logic [31:0]   shreg;
    logic          par;
    logic [7:0]    cfg;

    sl_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef SL_GLITCH_FILTER_EN
        ,
        .FILT_LEN(FILT_LEN)
`endif
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .line ({SL0, SL1}),
        .sym  (sym),
        .chg  (chg)
    );

    assign bit_val    = (sym == SYM_ONE);
    assign rx_busy    = (state != IDLE) && (state != ERR);
    assign r_config_w = cfg;
    // tcnt holds (cycles the current symbol has been seen) - 2 once chg has dropped
    assign tmo = rx_busy && !chg && (tcnt >= TW'(TIMEOUT_CYC - 2));

    always_comb begin
        state_nx = state;
        err      = 1'b0;
        start    = 1'b0;
        bump     = 1'b0;
        take_bit = 1'b0;
        take_par = 1'b0;
        done     = 1'b0;
        if (tmo) begin
            err = 1'b1;
        end else begin
            case (state)
                IDLE:   if (sym == SYM_STOP) err = 1'b1;
                        else if (sym != SYM_IDLE) begin
                            start    = 1'b1;
                            state_nx = BIT;
                        end
                BIT:    if (sym == SYM_IDLE) begin
                            bump     = 1'b1;
                            state_nx = GAP;
                        end else if (sym == SYM_STOP || chg) err = 1'b1;
                GAP:    if (sym == SYM_STOP) err = 1'b1;
                        else if (sym != SYM_IDLE) begin
                            if (bitcnt == nbits) begin
                                take_par = 1'b1;
                                state_nx = PARITY;
                            end else begin
                                take_bit = 1'b1;
                                state_nx = BIT;
                            end
                        end
                PARITY: if (sym == SYM_IDLE) state_nx = PGAP;
                        else if (sym == SYM_STOP || chg) err = 1'b1;
                PGAP:   if (sym == SYM_STOP) state_nx = STOP;
                        else if (sym != SYM_IDLE) err = 1'b1;
                STOP:   if (sym == SYM_IDLE) begin
                            done     = 1'b1;
                            state_nx = IDLE;
                        end else if (chg) err = 1'b1;
                ERR:    if (sym == SYM_IDLE && !chg && tcnt >= TW'(RESYNC_CYC - 2))
                            state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
        if (err) state_nx = ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tcnt       <= '0;
            bitcnt     <= '0;
            nbits      <= 6'd32;
            shreg      <= '0;
            par        <= 1'b0;
            cfg        <= CFG_RST;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state <= state_nx;
            if (chg)                            tcnt <= '0;
            else if (tcnt != TW'(TIMEOUT_CYC)) tcnt <= tcnt + TW'(1);
            if (cfg_wr) cfg <= wr_config_w;
            // Word length is frozen at the first symbol so mid-word config writes are safe
            if (start) begin
                bitcnt <= '0;
                nbits  <= (cfg[BQH:BQL] == 6'd0) ? 6'd32 : cfg[BQH:BQL];
                shreg  <= {31'b0, bit_val};
                par    <= bit_val;
            end
            if (bump) bitcnt <= bitcnt + 6'd1;
            if (take_bit) begin
                shreg[bitcnt[4:0]] <= bit_val;
                par                <= par ^ bit_val;
            end
            if (take_par) par <= par ^ bit_val;
            if (done) begin
                rx_data    <= shreg;
                parity_err <= par;
            end
            if (done)                      rx_valid <= 1'b1;
            else if (!cfg[IRQM] || rx_ack) rx_valid <= 1'b0;
            if (done && rx_valid && cfg[IRQM] && !rx_ack) overrun <= 1'b1;
            else if (rx_ack)                              overrun <= 1'b0;
            if (err)         frame_err <= 1'b1;
            else if (rx_ack) frame_err <= 1'b0;
        end
    end
endmodule
